// File: rtl/ad1_sample_sequencer.sv
// Run control and boxcar averaging for the dual-channel PmodAD1 poller.
// Captures num_sets sets of 2^avg_log2 conversions and emits each set's average over valid/ready.
module ad1_sample_sequencer #(
  parameter int DATA_WIDTH   = 12,
  parameter int AVG_LOG2_MAX = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [2:0]            avg_log2,
  input  logic [15:0]           num_sets,
  input  logic                  spi_drdy,
  input  logic [15:0]           spi_dout0,
  input  logic [15:0]           spi_dout1,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data0,
  output logic [DATA_WIDTH-1:0] m_data1,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);
  localparam int ACCW = DATA_WIDTH + AVG_LOG2_MAX;
  localparam int CW   = AVG_LOG2_MAX + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_e;

  state_e                state_q, state_d;
  logic                  drdy_q;
  logic [2:0]            avg_q, avg_d;
  logic [15:0]           nsets_q, nsets_d;
  logic [15:0]           set_cnt_q, set_cnt_d;
  logic [CW-1:0]         conv_cnt_q, conv_cnt_d;
  logic [ACCW-1:0]       acc0_q, acc0_d, acc1_q, acc1_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data0_q, m_data0_d, m_data1_q, m_data1_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;

  logic                  samp, conv_last;
  logic [2:0]            avg_clamp;
  logic [CW-1:0]         conv_tgt;
  logic [ACCW-1:0]       sum0, sum1, avg0, avg1;

  // drdy_q resets high so a poller already in its back porch does not look like a new conversion
  assign samp      = spi_drdy & ~drdy_q;
  assign avg_clamp = (int'(avg_log2) > AVG_LOG2_MAX) ? 3'(AVG_LOG2_MAX) : avg_log2;
  assign conv_tgt  = CW'((32'd1 << avg_q) - 32'd1);
  assign conv_last = (conv_cnt_q == conv_tgt);
  assign sum0      = acc0_q + ACCW'(spi_dout0[DATA_WIDTH-1:0]);
  assign sum1      = acc1_q + ACCW'(spi_dout1[DATA_WIDTH-1:0]);
  assign avg0      = sum0 >> avg_q;
  assign avg1      = sum1 >> avg_q;

  always_comb begin
    state_d    = state_q;
    avg_d      = avg_q;
    nsets_d    = nsets_q;
    set_cnt_d  = set_cnt_q;
    conv_cnt_d = conv_cnt_q;
    acc0_d     = acc0_q;
    acc1_d     = acc1_q;
    m_valid_d  = m_valid_q;
    m_data0_d  = m_data0_q;
    m_data1_d  = m_data1_q;
    overrun_d  = overrun_q;
    done_d     = 1'b0;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          avg_d      = avg_clamp;
          nsets_d    = num_sets;
          set_cnt_d  = '0;
          conv_cnt_d = '0;
          acc0_d     = '0;
          acc1_d     = '0;
          overrun_d  = 1'b0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (samp) begin
          if (conv_last) begin
            acc0_d     = '0;
            acc1_d     = '0;
            conv_cnt_d = '0;
            set_cnt_d  = set_cnt_q + 16'd1;
            // A result still waiting with no accept this cycle wins; the new one is dropped
            if (m_valid_q && !m_ready) begin
              overrun_d = 1'b1;
            end else begin
              m_valid_d = 1'b1;
              m_data0_d = avg0[DATA_WIDTH-1:0];
              m_data1_d = avg1[DATA_WIDTH-1:0];
            end
            if (nsets_q != 16'd0 && set_cnt_q + 16'd1 == nsets_q) state_d = FLUSH;
          end else begin
            acc0_d     = sum0;
            acc1_d     = sum1;
            conv_cnt_d = conv_cnt_q + CW'(1);
          end
        end
        if (stop) begin
          acc0_d     = '0;
          acc1_d     = '0;
          conv_cnt_d = '0;
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        if (!m_valid_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      drdy_q     <= 1'b1;
      avg_q      <= '0;
      nsets_q    <= '0;
      set_cnt_q  <= '0;
      conv_cnt_q <= '0;
      acc0_q     <= '0;
      acc1_q     <= '0;
      m_valid_q  <= 1'b0;
      m_data0_q  <= '0;
      m_data1_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      drdy_q     <= spi_drdy;
      avg_q      <= avg_d;
      nsets_q    <= nsets_d;
      set_cnt_q  <= set_cnt_d;
      conv_cnt_q <= conv_cnt_d;
      acc0_q     <= acc0_d;
      acc1_q     <= acc1_d;
      m_valid_q  <= m_valid_d;
      m_data0_q  <= m_data0_d;
      m_data1_q  <= m_data1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data0 = m_data0_q;
  assign m_data1 = m_data1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_ad1_sample_sequencer.sv
// Scoreboard bench for ad1_sample_sequencer: directed runs push expected averages,
// a negedge monitor pops and compares each accepted result.
module tb_ad1_sample_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [2:0]  avg_log2 = '0;
  logic [15:0] num_sets = '0;
  logic        spi_drdy = 1'b1;
  logic [15:0] spi_dout0 = '0, spi_dout1 = '0;
  logic        m_ready = 1'b0;
  logic        m_valid, busy, done, overrun;
  logic [11:0] m_data0, m_data1;

  ad1_sample_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .avg_log2(avg_log2), .num_sets(num_sets),
    .spi_drdy(spi_drdy), .spi_dout0(spi_dout0), .spi_dout1(spi_dout1),
    .m_valid(m_valid), .m_ready(m_ready), .m_data0(m_data0), .m_data1(m_data1),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0, done_cnt = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && done) done_cnt++;

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0d/%0d expected none", m_data0, m_data1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("m_data0", int'(m_data0), int'(mon_e[23:12]));
        chk("m_data1", int'(m_data1), int'(mon_e[11:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic go(input logic [2:0] a, input logic [15:0] n);
    avg_log2 = a; num_sets = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic conv(input logic [15:0] d0, input logic [15:0] d1);
    spi_drdy = 1'b0;
    step(); step();
    spi_dout0 = d0; spi_dout1 = d1; spi_drdy = 1'b1;
    step(); step();
  endtask

  task automatic wait_done(input string name);
    int base = done_cnt;
    int t = 0;
    while (done_cnt == base && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk(name, done_cnt - base, 1);
  endtask

  initial begin
    // 1: reset with drdy high
    repeat (4) step();
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data0", m_data0, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("idle_m_valid", m_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done_cnt, 0);

    // 2: average of four, latency check on the last conversion
    m_ready = 1'b1;
    exp_q.push_back({12'd102, 12'd4095});
    go(3'd2, 16'd1);
    conv(16'd100, 16'd4095);
    conv(16'd101, 16'd4095);
    conv(16'd102, 16'd4095);
    spi_drdy = 1'b0;
    step(); step();
    spi_dout0 = 16'd105; spi_dout1 = 16'd4095; spi_drdy = 1'b1;
    @(negedge clk);
    chk("t2_valid_before", m_valid, 0);
    step();
    @(negedge clk);
    chk("t2_valid_after", m_valid, 1);
    chk("t2_data0_direct", m_data0, 102);
    wait_done("t2_done");
    chk("t2_busy", busy, 0);

    // 3: back-pressure, sets 2 and 3 dropped
    m_ready = 1'b0;
    exp_q.push_back({12'd10, 12'd1});
    step();
    go(3'd0, 16'd3);
    conv(16'd10, 16'd1);
    conv(16'd20, 16'd2);
    conv(16'd30, 16'd3);
    repeat (4) @(negedge clk);
    chk("t3_overrun", overrun, 1);
    chk("t3_valid_held", m_valid, 1);
    chk("t3_data_held", m_data0, 10);
    chk("t3_busy_flush", busy, 1);
    chk("t3_no_done_yet", done_cnt, 1);
    step();
    m_ready = 1'b1;
    wait_done("t3_done");
    chk("t3_busy_end", busy, 0);
    chk("t3_overrun_sticky", overrun, 1);

    // 4: continuous, stop after five conversions
    exp_q.push_back({12'd15, 12'd1});
    exp_q.push_back({12'd40, 12'd150});
    step();
    go(3'd1, 16'd0);
    chk("t4_overrun_cleared", overrun, 0);
    conv(16'd10, 16'd1);
    conv(16'd20, 16'd2);
    conv(16'd30, 16'd100);
    conv(16'd50, 16'd201);
    conv(16'd7, 16'd9);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done("t4_done");
    chk("t4_busy", busy, 0);
    chk("t4_queue", exp_q.size(), 0);

    // 5: upper bits ignored, start-cycle drdy edge not counted
    exp_q.push_back({12'h123, 12'h456});
    spi_drdy = 1'b0;
    step(); step();
    avg_log2 = 3'd0; num_sets = 16'd1; start = 1'b1;
    spi_dout0 = 16'h0FFF; spi_dout1 = 16'h0FFF; spi_drdy = 1'b1;
    step();
    start = 1'b0;
    step();
    conv(16'hF123, 16'hA456);
    wait_done("t5_done");

    // 6: reset mid-run with a held result and overrun set
    m_ready = 1'b0;
    step();
    go(3'd0, 16'd0);
    conv(16'd5, 16'd6);
    conv(16'd7, 16'd8);
    @(negedge clk);
    chk("t6_overrun_pre", overrun, 1);
    chk("t6_valid_pre", m_valid, 1);
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_overrun", overrun, 0);
    chk("t6_rst_data0", m_data0, 0);
    chk("t6_rst_data1", m_data1, 0);
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    exp_q.push_back({12'd77, 12'd88});
    step();
    go(3'd0, 16'd1);
    conv(16'd77, 16'd88);
    wait_done("t6_done");
    chk("t6_overrun_clean", overrun, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
